// File: rtl/bitcoin_pkg.sv
// Shared SHA-256 constants, round helpers, block builders and the controller state type.
package bitcoin_pkg;

  typedef logic [31:0]      word_t;
  typedef logic [7:0][31:0] hstate_t;  // element j holds Hj (or working register a..h)
  typedef logic [15:0][31:0] block_t;  // element t holds message word Wt

  typedef enum logic [2:0] {
    StIdle, StLoad, StMid, StFetch, StBlk2, StBlk3, StWrite, StDone
  } state_e;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Written H7 first so that element 0 is H0.
  localparam hstate_t IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  function automatic word_t rotr(word_t x, int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(word_t x, word_t y, word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(word_t x, word_t y, word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t bsig0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Second block of the 80-byte header: tail words, nonce, padding, length 640 bits.
  function automatic block_t blk2_words(word_t w16, word_t w17, word_t w18, word_t nonce);
    block_t b;
    b     = '0;
    b[0]  = w16;
    b[1]  = w17;
    b[2]  = w18;
    b[3]  = nonce;
    b[4]  = 32'h80000000;
    b[15] = 32'd640;
    return b;
  endfunction

  // Single block hashing a 256-bit digest: digest, padding, length 256 bits.
  function automatic block_t blk3_words(hstate_t d);
    block_t b;
    b = '0;
    for (int i = 0; i < 8; i++) b[i] = d[i];
    b[8]  = 32'h80000000;
    b[15] = 32'd256;
    return b;
  endfunction

endpackage

// File: rtl/sha256_block_core.sv
// One SHA-256 compression: load init state and 16 words, 64 rounds, pulse done with init + regs.
module sha256_block_core
  import bitcoin_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    start_i,
  input  hstate_t init_i,
  input  block_t  words_i,
  output logic    done_o,
  output hstate_t sum_o
);

  hstate_t    init_q, init_d, regs_q, regs_d;
  block_t     w_q, w_d;
  logic [5:0] cnt_q, cnt_d;
  logic       busy_q, busy_d, done_q, done_d;
  word_t      t1, t2, w_new;

  // Round datapath; w_q[0] is always the current Wt, the window slides by one each round.
  always_comb begin
    init_d = init_q;
    regs_d = regs_q;
    w_d    = w_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    t1     = regs_q[7] + bsig1(regs_q[4]) + ch(regs_q[4], regs_q[5], regs_q[6]) + K[cnt_q]
             + w_q[0];
    t2     = bsig0(regs_q[0]) + maj(regs_q[0], regs_q[1], regs_q[2]);
    w_new  = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    if (start_i) begin
      init_d = init_i;
      regs_d = init_i;
      w_d    = words_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      regs_d[0] = t1 + t2;
      regs_d[1] = regs_q[0];
      regs_d[2] = regs_q[1];
      regs_d[3] = regs_q[2];
      regs_d[4] = regs_q[3] + t1;
      regs_d[5] = regs_q[4];
      regs_d[6] = regs_q[5];
      regs_d[7] = regs_q[6];
      for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
      w_d[15] = w_new;
      cnt_d   = cnt_q + 6'd1;
      if (cnt_q == 6'd63) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Control state with synchronous reset so an aborted job leaves nothing running.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Working registers are always reloaded on start, so they need no reset.
  always_ff @(posedge clk_i) begin
    init_q <= init_d;
    regs_q <= regs_d;
    w_q    <= w_d;
  end

  // Feed-forward sum, valid while done_o is high.
  always_comb begin
    for (int i = 0; i < 8; i++) sum_o[i] = init_q[i] + regs_q[i];
  end

  assign done_o = done_q;

endmodule

// File: rtl/bitcoin_hash_multi.sv
// Nonce-search controller: midstate once per job, then SHA-256d per nonce with target compare.
module bitcoin_hash_multi
  import bitcoin_pkg::*;
#(
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned OUT_WORDS  = 1,
  parameter int unsigned EARLY_EXIT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] nonce_base,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [8:0]        idx_q, idx_d;
  logic [31:0]       nonce_q, nonce_d, target_q, target_d, found_nonce_q, found_nonce_d;
  logic [15:0]       msg_addr_q, msg_addr_d, wr_addr_q, wr_addr_d;
  logic              found_q, found_d;
  logic [18:0][31:0] cache_q, cache_d;
  hstate_t           mid_q, mid_d, res_q, res_d;

  logic    core_start, core_done, hit, last_word, exit_now;
  hstate_t core_init, core_sum;
  block_t  core_words;

  sha256_block_core u_core (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .start_i (core_start),
    .init_i  (core_init),
    .words_i (core_words),
    .done_o  (core_done),
    .sum_o   (core_sum)
  );

  // Next-state, core sequencing and memory port.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    nonce_d        = nonce_q;
    target_d       = target_q;
    msg_addr_d     = msg_addr_q;
    wr_addr_d      = wr_addr_q;
    found_d        = found_q;
    found_nonce_d  = found_nonce_q;
    cache_d        = cache_q;
    mid_d          = mid_q;
    res_d          = res_q;
    core_start     = 1'b0;
    core_init      = IV;
    core_words     = cache_q[15:0];
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    hit            = res_q[0] < target_q;
    last_word      = cnt_q == 5'(OUT_WORDS - 1);
    // With early exit, found_q can only have been set by the nonce now being written.
    exit_now       = (EARLY_EXIT != 0) && (found_q || (cnt_q == 5'd0 && hit));
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d       = StLoad;
          cnt_d         = '0;
          idx_d         = '0;
          nonce_d       = nonce_base;
          target_d      = target;
          msg_addr_d    = message_addr;
          wr_addr_d     = output_addr;
          found_d       = 1'b0;
          found_nonce_d = '0;
        end
      end
      StLoad: begin
        // Reads issue on cnt 0..18; each word lands one cycle later.
        if (cnt_q != 5'd19) mem_addr = msg_addr_q + 16'(cnt_q);
        if (cnt_q != 5'd0) cache_d[cnt_q - 5'd1] = mem_read_data;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd19) begin
          state_d    = StMid;
          core_start = 1'b1;
        end
      end
      StMid: begin
        if (core_done) begin
          mid_d   = core_sum;
          state_d = StFetch;
        end
      end
      StFetch: begin
        core_start = 1'b1;
        core_init  = mid_q;
        core_words = blk2_words(cache_q[16], cache_q[17], cache_q[18], nonce_q);
        state_d    = StBlk2;
      end
      StBlk2: begin
        if (core_done) begin
          core_start = 1'b1;
          core_words = blk3_words(core_sum);
          state_d    = StBlk3;
        end
      end
      StBlk3: begin
        if (core_done) begin
          res_d   = core_sum;
          cnt_d   = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        mem_we         = 1'b1;
        mem_addr       = wr_addr_q;
        mem_write_data = res_q[cnt_q[2:0]];
        wr_addr_d      = wr_addr_q + 16'd1;
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'd0 && hit && !found_q) begin
          found_d       = 1'b1;
          found_nonce_d = nonce_q;
        end
        if (last_word) begin
          cnt_d = '0;
          if (exit_now || idx_q == 9'(NUM_NONCES - 1)) begin
            state_d = StDone;
          end else begin
            idx_d      = idx_q + 9'd1;
            nonce_d    = nonce_q + 32'd1;
            core_start = 1'b1;
            core_init  = mid_q;
            core_words = blk2_words(cache_q[16], cache_q[17], cache_q[18], nonce_q + 32'd1);
            state_d    = StBlk2;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and result flags; synchronous reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      idx_q         <= '0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
    end
  end

  // Job data; every field is reloaded before use after a start.
  always_ff @(posedge clk) begin
    nonce_q    <= nonce_d;
    target_q   <= target_d;
    msg_addr_q <= msg_addr_d;
    wr_addr_q  <= wr_addr_d;
    cache_q    <= cache_d;
    mid_q      <= mid_d;
    res_q      <= res_d;
  end

  assign done        = state_q == StDone;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign mem_clk     = clk;

endmodule
